// File: rtl/bip2_acc_ctrl.sv
// bip2_acc_ctrl: accumulator/status controller for the BIP-2 datapath.
// Accepts one decoded instruction at a time, fetches or stores a memory
// operand when the opcode needs it, drives the external Ula with ACC and
// the operand register, and writes the result back into ACC and STATUS.
module bip2_acc_ctrl #(
    parameter int DATA_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic              alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic [DATA_W-1:0] acc,
    output logic              status_z,
    output logic              status_n,
    output logic              done,
    output logic              halted
);

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_EXEC = 3'd3,
        ST_DONE = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    state_t            state_r;
    logic [4:0]        opc_r;
    logic [DATA_W-1:0] opnd_r;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] acc_r;
    logic              z_r;
    logic              n_r;
    logic              sel_r;
    logic              rd_r;
    logic              wr_r;
    logic              done_r;
    logic              halt_r;
    logic              ready_r;

    // Opcodes whose operand is a memory address to be read first.
    function automatic logic is_mem_read(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Opcodes that execute directly on the immediate operand.
    function automatic logic is_immediate(input logic [4:0] op);
        return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_SUBI);
    endfunction

    // Opcodes that make the Ula subtract.
    function automatic logic is_subtract(input logic [4:0] op);
        return (op == OP_SUB) || (op == OP_SUBI);
    endfunction

    // Control FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            opc_r   <= 5'd0;
            opnd_r  <= '0;
            addr_r  <= '0;
            acc_r   <= '0;
            z_r     <= 1'b0;
            n_r     <= 1'b0;
            sel_r   <= 1'b0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            done_r  <= 1'b0;
            halt_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opc_r   <= opcode;
                        addr_r  <= operand;
                        opnd_r  <= operand;
                        sel_r   <= is_subtract(opcode);
                        ready_r <= 1'b0;
                        if (is_mem_read(opcode)) begin
                            state_r <= ST_RD;
                            rd_r    <= 1'b1;
                        end else if (opcode == OP_STO) begin
                            state_r <= ST_WR;
                            wr_r    <= 1'b1;
                        end else if (is_immediate(opcode)) begin
                            state_r <= ST_EXEC;
                        end else if (opcode == OP_HLT) begin
                            state_r <= ST_HALT;
                            halt_r  <= 1'b1;
                        end else begin
                            // Unknown opcodes retire immediately as NOPs.
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_RD: begin
                    if (mem_ack) begin
                        opnd_r  <= mem_rdata;
                        rd_r    <= 1'b0;
                        state_r <= ST_EXEC;
                    end else begin
                        rd_r <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (mem_ack) begin
                        wr_r    <= 1'b0;
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        wr_r <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (opc_r)
                        OP_LD, OP_LDI: begin
                            acc_r <= opnd_r;
                        end
                        OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                            acc_r <= alu_result;
                            z_r   <= alu_z;
                            n_r   <= alu_n;
                        end
                        default: begin
                            acc_r <= acc_r;
                        end
                    endcase
                    state_r <= ST_DONE;
                    done_r  <= 1'b1;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                ST_HALT: begin
                    halt_r  <= 1'b1;
                    ready_r <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = ready_r;
    assign mem_addr    = addr_r;
    assign mem_rd      = rd_r;
    assign mem_wr      = wr_r;
    assign mem_wdata   = acc_r;
    assign alu_op1     = acc_r;
    assign alu_op2     = opnd_r;
    assign alu_sel     = sel_r;
    assign acc         = acc_r;
    assign status_z    = z_r;
    assign status_n    = n_r;
    assign done        = done_r;
    assign halted      = halt_r;

endmodule

// File: tb/tb_bip2_acc_ctrl.sv
// Testbench for bip2_acc_ctrl: a table of directed instructions, a block of
// random instructions checked against an arithmetic model, and hand-written
// sequences for NOP, reset during a read and HLT.
module tb_bip2_acc_ctrl;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         instr_valid = 1'b0;
    logic         instr_ready;
    logic [4:0]   opcode = 5'd0;
    logic [W-1:0] operand = '0;
    logic [W-1:0] mem_addr;
    logic         mem_rd, mem_wr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;
    logic [W-1:0] alu_op1, alu_op2, alu_result;
    logic         alu_sel, alu_z, alu_n;
    logic [W-1:0] acc;
    logic         status_z, status_n, done, halted;

    int total = 0;
    int bad   = 0;

    // bench memory (driven by the DUT) and model state
    logic [W-1:0] bmem [2048];
    int           m_mem [2048];
    int           m_acc, m_z, m_n;

    bip2_acc_ctrl #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .operand(operand),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_z(alu_z), .alu_n(alu_n),
        .acc(acc), .status_z(status_z), .status_n(status_n),
        .done(done), .halted(halted)
    );

    always #5 clk = ~clk;

    // Ula stand-in: combinational add/subtract with zero and sign flags
    assign alu_result = alu_sel ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);
    assign alu_z      = (alu_result == '0);
    assign alu_n      = alu_result[W-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model of one instruction: plain modular arithmetic over the spec rules
    task automatic model_step(input logic [4:0] op, input logic [W-1:0] opnd);
        int v, r;
        r = 0;
        case (op)
            5'd1: m_mem[opnd] = m_acc;
            5'd2: m_acc = m_mem[opnd];
            5'd3: m_acc = int'(opnd);
            5'd4, 5'd5, 5'd6, 5'd7: begin
                v = (op == 5'd4 || op == 5'd6) ? m_mem[opnd] : int'(opnd);
                if (op == 5'd4 || op == 5'd5) r = (m_acc + v) % 2048;
                else                          r = (m_acc + 2048 - v) % 2048;
                m_acc = r;
                m_z = (r == 0) ? 1 : 0;
                m_n = (r >= 1024) ? 1 : 0;
            end
            default: ;
        endcase
    endtask

    // expected cycles from handshake to the done pulse
    function automatic int exp_latency(input logic [4:0] op, input int dly);
        if (op == 5'd2 || op == 5'd4 || op == 5'd6) return dly + 2;
        if (op == 5'd1) return dly + 1;
        if (op == 5'd3 || op == 5'd5 || op == 5'd7) return 2;
        return 1;
    endfunction

    // issue one non-HLT instruction, serve memory with an ack after dly
    // request cycles, check latency, request stability and model state
    task automatic run_instr(input logic [4:0] op, input logic [W-1:0] opnd,
                             input int dly, input string tag);
        int  cyc, req, w;
        bit  seen_done;
        bit  is_mem;
        int  acc_before;
        w = 0;
        while (!instr_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
        acc_before  = m_acc;
        instr_valid = 1'b1;
        opcode      = op;
        operand     = opnd;
        @(negedge clk);
        instr_valid = 1'b0;
        opcode      = 5'($urandom);
        operand     = W'($urandom);
        cyc = 1;
        req = 0;
        seen_done = 1'b0;
        while (cyc < 60 && !seen_done) begin
            mem_ack = 1'b0;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (mem_rd || mem_wr) begin
                    req++;
                    chk({tag, "_addr"}, 32'(mem_addr), 32'(opnd));
                    if (mem_wr) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(acc_before));
                    if (req == dly) begin
                        mem_ack = 1'b1;
                        if (mem_rd) mem_rdata = bmem[mem_addr];
                        else        bmem[mem_addr] = mem_wdata;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen_done), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_latency(op, dly)));
        is_mem = (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6);
        chk({tag, "_req_cycles"}, 32'(req), is_mem ? 32'(dly) : 32'd0);
        model_step(op, opnd);
        chk({tag, "_acc"}, 32'(acc), 32'(m_acc));
        chk({tag, "_z"}, 32'(status_z), 32'(m_z));
        chk({tag, "_n"}, 32'(status_n), 32'(m_n));
        @(negedge clk);
        chk({tag, "_done_width"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(instr_ready), 32'd1);
    endtask

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] opnd;
        int           dly;
        logic [W-1:0] exp_acc;
        logic         exp_z;
        logic         exp_n;
    } vec_t;

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{5'h03, 11'h003, 0, 11'h003, 1'b0, 1'b0}; // LDI 3
        vecs[1]  = '{5'h05, 11'h002, 0, 11'h005, 1'b0, 1'b0}; // ADDI 2
        vecs[2]  = '{5'h03, 11'h003, 0, 11'h003, 1'b0, 1'b0}; // LDI 3
        vecs[3]  = '{5'h07, 11'h002, 0, 11'h001, 1'b0, 1'b0}; // SUBI 2
        vecs[4]  = '{5'h03, 11'h002, 0, 11'h002, 1'b0, 1'b0}; // LDI 2
        vecs[5]  = '{5'h07, 11'h003, 0, 11'h7FF, 1'b0, 1'b1}; // SUBI 3 wraps
        vecs[6]  = '{5'h03, 11'h003, 0, 11'h003, 1'b0, 1'b1}; // LDI keeps STATUS
        vecs[7]  = '{5'h06, 11'h010, 4, 11'h000, 1'b1, 1'b0}; // SUB [0x010]=3
        vecs[8]  = '{5'h03, 11'h123, 0, 11'h123, 1'b1, 1'b0}; // LDI 0x123
        vecs[9]  = '{5'h01, 11'h005, 3, 11'h123, 1'b1, 1'b0}; // STO 0x005
        vecs[10] = '{5'h02, 11'h005, 1, 11'h123, 1'b1, 1'b0}; // LD 0x005
        vecs[11] = '{5'h04, 11'h005, 2, 11'h246, 1'b0, 1'b0}; // ADD 0x005
        vecs[12] = '{5'h08, 11'h7FF, 0, 11'h246, 1'b0, 1'b0}; // NOP 01000
        vecs[13] = '{5'h1F, 11'h000, 0, 11'h246, 1'b0, 1'b0}; // NOP 11111

        for (int i = 0; i < 2048; i++) begin
            bmem[i]  = W'($urandom);
            m_mem[i] = int'(bmem[i]);
        end
        bmem[16]  = 11'h003;
        m_mem[16] = 3;
        m_acc = 0;
        m_z = 0;
        m_n = 0;

        // reset
        repeat (3) @(negedge clk);
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_flags", {30'd0, status_z, status_n}, 32'd0);
        chk("rst_done", 32'(done), 32'd0);

        // directed table
        for (int i = 0; i < 14; i++) begin
            run_instr(vecs[i].op, vecs[i].opnd, vecs[i].dly, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_tbl_acc", i), 32'(acc), 32'(vecs[i].exp_acc));
            chk($sformatf("vec%0d_tbl_flags", i), {30'd0, status_z, status_n},
                {30'd0, vecs[i].exp_z, vecs[i].exp_n});
        end

        // random instructions against the model
        for (int i = 0; i < 60; i++) begin
            int r;
            logic [4:0]   op;
            logic [W-1:0] opnd;
            r = $urandom_range(0, 8);
            op = (r < 7) ? 5'(r + 1) : 5'($urandom_range(8, 31));
            if (op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd6)
                opnd = W'($urandom_range(0, 15));
            else
                opnd = W'($urandom);
            run_instr(op, opnd, $urandom_range(1, 4), $sformatf("rnd%0d", i));
        end

        // reset while a read is pending
        run_instr(5'h03, 11'h2AA, 0, "pre_rst");
        instr_valid = 1'b1;
        opcode      = 5'h02;
        operand     = 11'h007;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rdrst_rd_before", 32'(mem_rd), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rdrst_rd_drop", 32'(mem_rd), 32'd0);
        chk("rdrst_acc", 32'(acc), 32'd0);
        chk("rdrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0;
        m_z = 0;
        m_n = 0;
        for (int i = 0; i < 3; i++) begin
            chk("rdrst_idle_ready", 32'(instr_ready), 32'd1);
            chk("rdrst_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        run_instr(5'h05, 11'h004, 0, "post_rst");

        // HLT with valid held afterwards
        instr_valid = 1'b1;
        opcode      = 5'h00;
        operand     = 11'h000;
        @(negedge clk);
        opcode = 5'h03;
        operand = 11'h055;
        for (int i = 0; i < 10; i++) begin
            chk("hlt_halted", 32'(halted), 32'd1);
            chk("hlt_ready", 32'(instr_ready), 32'd0);
            chk("hlt_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("hlt_acc_kept", 32'(acc), 32'(m_acc));
        instr_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
